// File: rtl/substraction_pkg.sv
// substraction_pkg: shared width constant for the 4-bit subtractor slice.
`default_nettype none
package substraction_pkg;
  localparam int unsigned WIDTH = 4;
endpackage
`default_nettype wire

// File: rtl/substraction_full_subtractor.sv
// ---------------------------------------------------------------------------
// substraction_full_subtractor : one-bit full subtractor cell (a - b - bin)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module substraction_full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  logic w_axb;

  assign w_axb  = a_i ^ b_i;
  assign d_o    = w_axb ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~w_axb & bin_i);
endmodule
`default_nettype wire

// File: rtl/substraction.sv
// ---------------------------------------------------------------------------
// substraction : registered 4-bit unsigned subtractor, D = (X - Y) mod 16
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module substraction
  import substraction_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  output logic o0,
  output logic o1,
  output logic o2,
  output logic o3,
  output logic borrow
);
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_b;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_d;
  logic             borrow_q;

  assign w_x    = {x3, x2, x1, x0};
  assign w_y    = {y3, y2, y1, y0};
  assign w_b[0] = 1'b0;

  // Ripple-borrow chain: each cell's borrow-out feeds the next cell's borrow-in.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    substraction_full_subtractor u_fs (
      .a_i    (w_x[i]),
      .b_i    (w_y[i]),
      .bin_i  (w_b[i]),
      .d_o    (diff_d[i]),
      .bout_o (w_b[i+1])
    );
  end

  assign borrow_d = w_b[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign {o3, o2, o1, o0} = diff_q;
  assign borrow           = borrow_q;
endmodule
`default_nettype wire

// File: tb/tb_substraction.sv
// tb_substraction: self-checking bench for the registered 4-bit subtractor.
`default_nettype none
module tb_substraction;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x0 = 1'b0, x1 = 1'b0, x2 = 1'b0, x3 = 1'b0;
  logic y0 = 1'b0, y1 = 1'b0, y2 = 1'b0, y3 = 1'b0;
  logic o0, o1, o2, o3, borrow;
  int   checks = 0;
  int   failures = 0;

  substraction dut (
    .clk(clk), .rst(rst),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] dout();
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [3:0] ref_diff(int x, int y);
    int d;
    d = x - y;
    if (d < 0) d = d + 16;
    return d[3:0];
  endfunction

  function automatic logic ref_borrow(int x, int y);
    return x < y;
  endfunction

  task automatic drive(input int x, input int y);
    logic [3:0] xv, yv;
    xv = x[3:0];
    yv = y[3:0];
    {x3, x2, x1, x0} = xv;
    {y3, y2, y1, y0} = yv;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(9, 3);
    #2;
    checks++;
    if (dout() !== 4'd0 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got d=%0d b=%0b want d=0 b=0", dout(), borrow);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_settle();
    checks++;
    if (dout() !== 4'd6 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_capture: got d=%0d b=%0b want d=6 b=0", dout(), borrow);
    end
  endtask

  task automatic test_latency();
    drive(12, 5);
    edge_settle();
    checks++;
    if (dout() !== 4'd7 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL latency_n: got d=%0d b=%0b want d=7 b=0", dout(), borrow);
    end
    drive(2, 7);
    #2;
    checks++;
    if (dout() !== 4'd7 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL latency_hold: got d=%0d b=%0b want d=7 b=0", dout(), borrow);
    end
    edge_settle();
    checks++;
    if (dout() !== 4'd11 || borrow !== 1'b1) begin
      failures++;
      $display("FAIL latency_n1: got d=%0d b=%0b want d=11 b=1", dout(), borrow);
    end
  endtask

  task automatic test_sweep();
    int errs = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        drive(x, y);
        edge_settle();
        checks++;
        if (dout() !== ref_diff(x, y) || borrow !== ref_borrow(x, y)) begin
          failures++;
          errs++;
          if (errs <= 8)
            $display("FAIL sweep x=%0d y=%0d: got d=%0d b=%0b want d=%0d b=%0b",
                     x, y, dout(), borrow, ref_diff(x, y), ref_borrow(x, y));
        end
      end
    end
  endtask

  task automatic test_boundaries();
    int bx[4] = '{0, 15, 0, 15};
    int by[4] = '{1, 15, 15, 0};
    logic [3:0] ed[4] = '{4'd15, 4'd0, 4'd1, 4'd15};
    logic       eb[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(bx[k], by[k]);
      edge_settle();
      checks++;
      if (dout() !== ed[k] || borrow !== eb[k]) begin
        failures++;
        $display("FAIL boundary x=%0d y=%0d: got d=%0d b=%0b want d=%0d b=%0b",
                 bx[k], by[k], dout(), borrow, ed[k], eb[k]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    drive(10, 4);
    edge_settle();
    checks++;
    if (dout() !== 4'd6 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_before: got d=%0d b=%0b want d=6 b=0", dout(), borrow);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dout() !== 4'd0 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: got d=%0d b=%0b want d=0 b=0", dout(), borrow);
    end
    edge_settle();
    checks++;
    if (dout() !== 4'd0 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_hold: got d=%0d b=%0b want d=0 b=0", dout(), borrow);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_settle();
    checks++;
    if (dout() !== 4'd6 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_release: got d=%0d b=%0b want d=6 b=0", dout(), borrow);
    end
  endtask

  task automatic test_signed();
    drive(3, 5);
    edge_settle();
    checks++;
    if ($signed(dout()) !== -4'sd2 || borrow !== 1'b1) begin
      failures++;
      $display("FAIL signed_3m5: got d=%0d b=%0b want d=-2 b=1", $signed(dout()), borrow);
    end
    drive(8, 1);
    edge_settle();
    checks++;
    if (dout() !== 4'd7 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL signed_m8m1: got d=%0d b=%0b want d=7 b=0", dout(), borrow);
    end
  endtask

  task automatic test_random();
    int x, y;
    for (int k = 0; k < 64; k++) begin
      x = int'($urandom_range(15, 0));
      y = int'($urandom_range(15, 0));
      drive(x, y);
      edge_settle();
      checks++;
      if (dout() !== ref_diff(x, y) || borrow !== ref_borrow(x, y)) begin
        failures++;
        $display("FAIL random x=%0d y=%0d: got d=%0d b=%0b want d=%0d b=%0b",
                 x, y, dout(), borrow, ref_diff(x, y), ref_borrow(x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sweep();
    test_boundaries();
    test_midstream_reset();
    test_signed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/substraction.md
Name: substraction

Overview:
- 4-bit unsigned subtractor: o = x − y modulo 16, plus a borrow-out flag.
- Operands and result are presented as individual scalar bit ports. Result is registered (one pipeline stage) so the block drops into the synchronous datapath of the arithmetic unit alongside the adder.
- Internally a ripple-borrow chain of four full-subtractor cells.

Parameters:
- None. Width is fixed at 4 bits by the scalar port list.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- x0  input  1  minuend bit 0 (LSB)
- x1  input  1  minuend bit 1
- x2  input  1  minuend bit 2
- x3  input  1  minuend bit 3 (MSB)
- y0  input  1  subtrahend bit 0 (LSB)
- y1  input  1  subtrahend bit 1
- y2  input  1  subtrahend bit 2
- y3  input  1  subtrahend bit 3 (MSB)
- o0  output  1  difference bit 0 (LSB), registered
- o1  output  1  difference bit 1, registered
- o2  output  1  difference bit 2, registered
- o3  output  1  difference bit 3 (MSB), registered
- borrow  output  1  borrow-out of bit 3: 1 when x < y (unsigned), registered

Behaviour:
- Operand bit order: X = {x3,x2,x1,x0}, Y = {y3,y2,y1,y0}, D = {o3,o2,o1,o0}; bit 0 is LSB.
- Combinational core, per bit i, with b_in(0) = 0:
  - d_i = x_i ^ y_i ^ b_in_i
  - b_out_i = (~x_i & y_i) | (~(x_i ^ y_i) & b_in_i)
  - b_in_(i+1) = b_out_i; borrow = b_out_3.
- Arithmetic result: D = (X − Y) mod 16. Equivalently X + ~Y + 1 with borrow = NOT carry-out.
- Two's-complement reading of D is valid when the inputs are taken as signed. Signed overflow is not flagged.
- Timing: on each rising clk edge with rst low, o0..o3 and borrow capture the combinational result of the inputs sampled at that edge. Latency is exactly 1 cycle; throughput is one subtraction per cycle.
- No enable and no valid handshake: outputs update every cycle.
- Reset: rst high asynchronously forces o0..o3 = 0 and borrow = 0 immediately, with no clock needed. Values hold at 0 while rst is high.
- First capture after reset: the first rising edge with rst low captures the current inputs.
- Reset mid-operation: an in-flight result is discarded, not held or replayed.
- Boundary conditions:
  - X = Y → D = 0, borrow = 0.
  - X = 0, Y = 15 → D = 1, borrow = 1.
  - X = 15, Y = 0 → D = 15, borrow = 0.
  - X = 0, Y = 1 → D = 15, borrow = 1 (wrap-around).
- Inputs carrying X/Z are not required to be handled. Outputs may go X for that cycle.

Decomposition:
- No shared package needed. At most a localparam WIDTH = 4 inside the module for generate loops.
- One natural sub-module: full_subtractor (inputs a, b, bin; outputs d, bout), instantiated four times in a ripple chain.
- Output register bank lives in the top module.

Test Plan:
- Reset: assert rst with inputs X=9, Y=3, no clock edge → o3..o0 = 0000 and borrow = 0 immediately. Deassert rst, one edge → D=6 (0110), borrow=0.
- Latency check: apply X=12, Y=5 at edge n → D=7, borrow=0 visible after edge n. Change to X=2, Y=7 before edge n+1 → D=11 (1011), borrow=1 after edge n+1; previous value held between edges.
- Exhaustive sweep: all 256 (X,Y) pairs, one per cycle → each output equals (X−Y) mod 16 and borrow = (X<Y) one cycle later. Order X outer loop, Y inner, 0..15.
- Boundaries:
  - X=0, Y=1 → D=15, borrow=1.
  - X=15, Y=15 → D=0, borrow=0.
  - X=0, Y=15 → D=1, borrow=1.
  - X=15, Y=0 → D=15, borrow=0.
- Mid-stream reset: stream X=10, Y=4 continuously. Pulse rst between edges → outputs drop to 0 asynchronously. The first edge after release yields D=6.
- Signed interpretation: X=3, Y=5 → D=14 (reads as −2), borrow=1. X=−8 (8), Y=1 → D=7, no overflow flag required.
